// File: rtl/cpu_exec_sequencer_if.sv
// Front-panel / CPU-core signal bundle for cpu_exec_sequencer.
// master = panel and core side, slave = the sequencer itself.
interface cpu_exec_sequencer_if #(
    parameter int unsigned IP_W = 8
);
    logic            Turbo;
    logic            Run_req;
    logic            Step_req;
    logic            Halt_req;
    logic [IP_W-1:0] IP;
    logic [IP_W-1:0] Brk_addr;
    logic            Brk_valid;
    logic            Go;
    logic [1:0]      State;
    logic            Tick;
    logic [15:0]     Step_count;

    modport master (
        output Turbo, Run_req, Step_req, Halt_req, IP, Brk_addr, Brk_valid,
        input  Go, State, Tick, Step_count
    );

    modport slave (
        input  Turbo, Run_req, Step_req, Halt_req, IP, Brk_addr, Brk_valid,
        output Go, State, Tick, Step_count
    );
endinterface

// File: rtl/cpu_exec_sequencer.sv
// Execution controller issuing the one-cycle Go enable (PAUSE/RUN/STEP/BREAK).
// Breakpoint support is compiled in only when SEQ_BREAKPOINT_EN is defined.
module cpu_exec_sequencer #(
    parameter int unsigned TICK_MAX = 12499999,
    parameter int unsigned CNT_W    = 24,
    parameter int unsigned IP_W     = 8
) (
    input logic                 Clock,
    input logic                 Reset,
    cpu_exec_sequencer_if.slave Seq
);
    typedef enum logic [1:0] {
        S_PAUSE = 2'b00,
        S_RUN   = 2'b01,
        S_STEP  = 2'b10,
        S_BREAK = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] TICK_TERM = CNT_W'(TICK_MAX);

    state_e           state_q, state_d;
    logic             go_q, go_d;
    logic             tick_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      count_q, count_d;
    logic             step_prev_q;
    logic             step_edge;
    logic             fire;
    logic             leave_run;
    logic             brk_hit;

    assign step_edge = Seq.Step_req & ~step_prev_q;
    assign fire      = Seq.Turbo | (cnt_q == TICK_TERM);
    assign leave_run = Seq.Halt_req | ~Seq.Run_req;
    assign cnt_d     = (cnt_q == TICK_TERM) ? '0 : cnt_q + CNT_W'(1);
    assign count_d   = (go_q && (count_q != '1)) ? count_q + 16'd1 : count_q;

`ifdef SEQ_BREAKPOINT_EN
    logic brk_armed_q, brk_armed_d;

    assign brk_hit = fire & Seq.Brk_valid & brk_armed_q
                   & (Seq.IP[IP_W-1:0] == Seq.Brk_addr[IP_W-1:0]);

    // Disarm on the hit; rearm only once a Go has actually been issued so the
    // resumed instruction at the breakpoint address executes instead of re-breaking.
    always_comb begin
        brk_armed_d = brk_armed_q;
        if (go_q) begin
            brk_armed_d = 1'b1;
        end
        if ((state_q == S_RUN) && !leave_run && brk_hit) begin
            brk_armed_d = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            brk_armed_q <= 1'b1;
        end else begin
            brk_armed_q <= brk_armed_d;
        end
    end
`else
    logic [IP_W-1:0] unused_brk_bus;
    logic            unused_brk_valid;

    assign unused_brk_bus   = Seq.IP ^ Seq.Brk_addr;
    assign unused_brk_valid = Seq.Brk_valid;
    assign brk_hit          = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= S_PAUSE;
            go_q        <= 1'b0;
            tick_q      <= 1'b0;
            cnt_q       <= '0;
            count_q     <= '0;
            step_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            go_q        <= go_d;
            tick_q      <= (cnt_q == TICK_TERM);
            cnt_q       <= cnt_d;
            count_q     <= count_d;
            step_prev_q <= Seq.Step_req;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_PAUSE: begin
                if (!Seq.Halt_req) begin
                    if (Seq.Run_req) begin
                        state_d = S_RUN;
                    end else if (step_edge) begin
                        state_d = S_STEP;
                    end
                end
            end
            S_RUN: begin
                if (leave_run) begin
                    state_d = S_PAUSE;
                end else if (brk_hit) begin
                    state_d = S_BREAK;
                end
            end
            S_STEP: state_d = S_PAUSE;
            S_BREAK: begin
                if (leave_run) begin
                    state_d = S_PAUSE;
                end else if (step_edge) begin
                    state_d = S_STEP;
                end
            end
            default: state_d = S_PAUSE;
        endcase
    end

    always_comb begin
        go_d = 1'b0;
        case (state_q)
            S_RUN:   go_d = ~leave_run & fire & ~brk_hit;
            S_STEP:  go_d = ~Seq.Halt_req;
            default: go_d = 1'b0;
        endcase
    end

    assign Seq.Go         = go_q;
    assign Seq.State      = state_q;
    assign Seq.Tick       = tick_q;
    assign Seq.Step_count = count_q;
endmodule

// File: tb/tb_cpu_exec_sequencer.sv
// Directed bench for cpu_exec_sequencer: per-cycle compare against a mode-level model
// plus hand-computed literal expectations for each scenario.
module tb_cpu_exec_sequencer;
    localparam int TMAX = 3;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    cpu_exec_sequencer_if #(.IP_W(8)) bus();

    logic [7:0] m_ip = 8'd0;
    assign bus.IP = m_ip;

    cpu_exec_sequencer #(.TICK_MAX(TMAX), .CNT_W(24), .IP_W(8)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .Seq   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: modes 0 pause, 1 run, 2 step, 3 break; outputs are what the DUT must
    // show after each rising edge. The prescaler is cycles-since-reset modulo TMAX+1.
    int m_mode  = 0;
    int m_count = 0;
    int m_cyc   = 0;
    int n_mode;
    bit m_go = 0, m_tick = 0, m_prev = 1, m_armed = 1, m_started = 0;
    bit stepped, fire_now, hit, n_go;

    always @(posedge Clock) begin
        m_ip <= Reset ? 8'd0 : m_ip + (m_go ? 8'd1 : 8'd0);
        if (Reset) begin
            m_mode = 0; m_go = 0; m_tick = 0; m_prev = 1; m_armed = 1;
            m_count = 0; m_cyc = 0; m_started = 1;
        end else if (m_started) begin
            stepped  = bus.Step_req && !m_prev;
            fire_now = bus.Turbo || ((m_cyc % (TMAX + 1)) == TMAX);
            hit      = 0;
`ifdef SEQ_BREAKPOINT_EN
            hit = fire_now && bus.Brk_valid && m_armed && (m_ip == bus.Brk_addr);
`endif
            n_go   = 0;
            n_mode = m_mode;
            if (bus.Halt_req) begin
                n_mode = 0;
            end else if (m_mode == 0) begin
                if (bus.Run_req) n_mode = 1;
                else if (stepped) n_mode = 2;
            end else if (m_mode == 1) begin
                if (!bus.Run_req) n_mode = 0;
                else if (hit) n_mode = 3;
                else n_go = fire_now;
            end else if (m_mode == 2) begin
                n_go   = 1;
                n_mode = 0;
            end else begin
                if (!bus.Run_req) n_mode = 0;
                else if (stepped) n_mode = 2;
            end
            if (m_go && m_count < 65535) m_count = m_count + 1;
            if (m_go) m_armed = 1;
            if (n_mode == 3 && m_mode == 1) m_armed = 0;
            m_tick = ((m_cyc % (TMAX + 1)) == TMAX);
            m_cyc  = m_cyc + 1;
            m_prev = bus.Step_req;
            m_mode = n_mode;
            m_go   = n_go;
        end
    end

    always @(negedge Clock) begin
        if (m_started) begin
            check("go", bus.Go, m_go);
            check("state", bus.State, m_mode);
            check("tick", bus.Tick, m_tick);
            check("step_count", bus.Step_count, m_count);
        end
    end

    task automatic run_count(input int n, output int pulses, output int brk_seen);
        pulses   = 0;
        brk_seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            if (bus.Go) pulses++;
            if (bus.State == 2'b11) brk_seen++;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
    endtask

`ifdef SEQ_BREAKPOINT_EN
    task automatic run_to_break(input string tag);
        int pulses;
        bit found;
        pulses = 0;
        found  = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge Clock);
            if (bus.Go) pulses++;
            if (bus.State == 2'b11) found = 1;
        end
        check({tag, "_reached"}, found, 1);
        check({tag, "_pulses"}, pulses, 5);
        check({tag, "_count"}, bus.Step_count, 5);
    endtask
`endif

    int pulses, brk, prev_i, gaps_bad, st1, st2;

    initial begin
        Reset = 1'b1;
        bus.Turbo = 0; bus.Run_req = 1; bus.Step_req = 0; bus.Halt_req = 0;
        bus.Brk_addr = 8'h00; bus.Brk_valid = 0;
        repeat (2) @(negedge Clock);
        check("rst_go", bus.Go, 0);
        check("rst_state", bus.State, 0);
        check("rst_tick", bus.Tick, 0);
        check("rst_count", bus.Step_count, 0);
        Reset = 1'b0;

        // Free-run at prescaled rate: a pulse every TMAX+1 cycles.
        pulses = 0; prev_i = -1; gaps_bad = 0;
        for (int i = 1; i <= 21; i++) begin
            @(negedge Clock);
            if (bus.Go) begin
                pulses++;
                if (prev_i >= 0 && (i - prev_i) != 4) gaps_bad++;
                prev_i = i;
            end
        end
        check("free_pulses", pulses, 5);
        check("free_gap", gaps_bad, 0);
        check("free_count", bus.Step_count, 5);
        check("free_state", bus.State, 1);

        // Turbo: ten back-to-back pulses, then drop Run_req.
        bus.Turbo = 1;
        run_count(10, pulses, brk);
        check("turbo_pulses", pulses, 10);
        bus.Run_req = 0;
        @(negedge Clock);
        check("turbo_stop_go", bus.Go, 0);
        check("turbo_stop_state", bus.State, 0);
        check("turbo_count", bus.Step_count, 15);

        // Single step from PAUSE with Step_req held.
        bus.Turbo = 0;
        bus.Step_req = 1;
        pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge Clock);
            if (bus.Go) pulses++;
            if (i == 1) st1 = bus.State;
            if (i == 2) st2 = bus.State;
        end
        check("step_pulses", pulses, 1);
        check("step_state_entry", st1, 2);
        check("step_state_exit", st2, 0);
        check("step_count", bus.Step_count, 16);

        // Step_req held through reset must not step; a fresh press does.
        do_reset();
        run_count(5, pulses, brk);
        check("step_thru_reset", pulses, 0);
        bus.Step_req = 0;
        @(negedge Clock);
        bus.Step_req = 1;
        run_count(5, pulses, brk);
        check("repress_pulses", pulses, 1);
        check("repress_count", bus.Step_count, 1);

        // Halt and step edge together while running turbo.
        bus.Step_req = 0; bus.Run_req = 1; bus.Turbo = 1;
        run_count(5, pulses, brk);
        bus.Halt_req = 1; bus.Step_req = 1;
        @(negedge Clock);
        check("halt_go", bus.Go, 0);
        check("halt_state", bus.State, 0);
        run_count(2, pulses, brk);
        check("halt_hold_pulses", pulses, 0);
        bus.Halt_req = 0; bus.Step_req = 0; bus.Run_req = 0; bus.Turbo = 0;
        @(negedge Clock);
        bus.Run_req = 1; bus.Step_req = 1;
        @(negedge Clock);
        check("run_beats_step", bus.State, 1);
        bus.Run_req = 0; bus.Step_req = 0;
        repeat (2) @(negedge Clock);

`ifdef SEQ_BREAKPOINT_EN
        // Break at 5, resume by stepping, then keep running.
        bus.Run_req = 0; bus.Brk_addr = 8'h05; bus.Brk_valid = 1;
        do_reset();
        bus.Run_req = 1;
        run_to_break("brk1");
        bus.Step_req = 1;
        @(negedge Clock);
        check("brk_step_state", bus.State, 2);
        bus.Run_req = 0;
        @(negedge Clock);
        check("brk_step_go", bus.Go, 1);
        check("brk_step_exit", bus.State, 0);
        bus.Step_req = 0;
        @(negedge Clock);
        bus.Run_req = 1;
        run_count(30, pulses, brk);
        check("brk1_no_rebreak", brk, 0);
        check("brk1_runs", pulses > 0, 1);

        // Break again, resume via PAUSE then RUN at the breakpoint address.
        bus.Run_req = 0;
        do_reset();
        bus.Run_req = 1;
        run_to_break("brk2");
        bus.Run_req = 0;
        @(negedge Clock);
        check("brk2_pause", bus.State, 0);
        bus.Run_req = 1;
        run_count(30, pulses, brk);
        check("brk2_no_rebreak", brk, 0);
        check("brk2_runs", pulses > 0, 1);
        bus.Brk_valid = 0;
`else
        // Breakpoint inputs have no effect in this build.
        bus.Brk_addr = 8'h00; bus.Brk_valid = 1;
        do_reset();
        bus.Run_req = 1; bus.Turbo = 1;
        run_count(20, pulses, brk);
        check("nobrk_state", brk, 0);
        check("nobrk_pulses", pulses, 19);
        bus.Brk_valid = 0;
`endif

        // Saturation, then reset in the middle of a pulse.
        bus.Run_req = 1; bus.Turbo = 1;
        do_reset();
        repeat (65540) @(negedge Clock);
        check("sat_count", bus.Step_count, 16'hFFFF);
        check("sat_go", bus.Go, 1);
        Reset = 1'b1;
        @(negedge Clock);
        check("midrst_go", bus.Go, 0);
        check("midrst_count", bus.Step_count, 0);
        check("midrst_state", bus.State, 0);
        Reset = 1'b0;
        @(negedge Clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_exec_sequencer.md
Name: cpu_exec_sequencer

Overview:
Execution controller for the 8-bit CPU core. Generates the single-cycle instruction-enable pulse `Go` that gates every IP update and register write in the instruction cycle block. Supports four execution modes: free-run at prescaled rate, turbo (every clock), single-step from a button, and pause. Sits between the synchronised front-panel inputs and the CPU core, replacing the core's fixed cnt==0/Turbo gating.

Parameters:
TICK_MAX, 12499999, prescaler terminal count (250 ms at 50 MHz); bench uses 3
CNT_W, 24, prescaler width; must hold TICK_MAX
IP_W, 8, instruction-pointer width

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-high; clock Clock
Turbo  in  1  already synchronised; 1 = issue Go every cycle while RUN
Run_req  in  1  synchronised level; 1 = run requested
Step_req  in  1  synchronised level; rising edge = one-instruction step
Halt_req  in  1  synchronised level; forces PAUSE, highest priority
IP  in  IP_W  current CPU instruction pointer
Brk_addr  in  IP_W  breakpoint address (used only with feature)
Brk_valid  in  1  breakpoint enable (used only with feature)
Go  out  1  registered one-cycle instruction enable to CPU
State  out  2  00 PAUSE, 01 RUN, 10 STEP, 11 BREAK
Tick  out  1  registered, high for one cycle when prescaler wraps
Step_count  out  16  instructions issued (count of Go pulses), saturating

Behaviour:
- Reset (sync): State=PAUSE, prescaler=0, Go=0, Tick=0, Step_count=0, step_prev=1, brk_armed=1. step_prev=1 means a Step_req held through reset does not trigger a step.
- Prescaler: free-running in every state; counts 0..TICK_MAX then wraps to 0. Tick <= (cnt==TICK_MAX).
- step_edge = Step_req & ~step_prev; step_prev <= Step_req every cycle.
- Go is registered. It asserts the cycle after its condition is sampled, is never high for two consecutive cycles except in RUN with Turbo=1, and is 0 in any cycle following a Reset cycle.
- PAUSE:
  - Halt_req: stay in PAUSE.
  - else Run_req=1: go to RUN. Run_req wins over a simultaneous step_edge.
  - else step_edge: go to STEP.
  - Go=0 throughout.
- RUN:
  - Halt_req=1 or Run_req=0: go to PAUSE; no Go is issued that cycle.
  - else fire = Turbo | (cnt==TICK_MAX). On fire: Go<=1.
  - step_edge is ignored.
- STEP: Go<=1 on entry cycle (exactly one pulse), then go to PAUSE. Halt_req on the entry cycle suppresses the pulse and goes to PAUSE.
- BREAK: reachable only with the feature enabled.
  - Go=0.
  - Halt_req or Run_req=0: go to PAUSE.
  - step_edge: go to STEP.
- Step_count increments on each cycle Go=1; holds at 0xFFFF.
- Reset mid-pulse: Go drops the next cycle and all state reinitialises. No partial step is retained.

Optional Feature:
Macro SEQ_BREAKPOINT_EN.
- Defined:
  - In RUN, when fire, Brk_valid=1, brk_armed=1 and IP==Brk_addr: Go is suppressed, State goes to BREAK, brk_armed<=0.
  - brk_armed<=1 after the next Go is issued. Resuming (step, or PAUSE then RUN) therefore executes the breakpointed instruction without re-breaking.
- Undefined: Brk_addr and Brk_valid are ignored, State never equals 11, brk_armed logic is absent.

Test Plan:
- TICK_MAX=3, Run_req=1, Turbo=0 from reset → Go pulses exactly every 4 cycles; Step_count = 5 after 5 pulses; State=01.
- RUN with Turbo=1 for 10 cycles → Go high 10 consecutive cycles; Step_count += 10. Drop Run_req → Go=0 next cycle, State=00.
- PAUSE; Step_req 0→1 held 20 cycles → exactly one Go pulse; State path 00→10→00. Step_req high through Reset then released and re-pressed → only the post-release press steps.
- RUN, Turbo=1; Halt_req and Step_req rise in same cycle → no Go, State=00. Run_req and step_edge together in PAUSE → State=01.
- With SEQ_BREAKPOINT_EN: Brk_addr=8'h05, Brk_valid=1, Turbo=1, IP counting from 0 → Go pulses for IP 0..4, no Go at IP=5, State=11. Step edge → one Go, State 10→00. Run_req 0→1 → runs past IP=5 without breaking.
- Step_count preloaded near limit via 65540 turbo cycles → saturates at 0xFFFF. Reset mid-RUN → Go=0, Step_count=0, State=00 on the next cycle.
